// File: rtl/window_apply_if.sv
// Bundle of the FIFO-manager/memory read side and the FFT stream side of window_apply.
// master = the windowing stage, slave = its environment.
interface window_apply_if #(
    parameter int ADDRWIDTH = 12,
    parameter int DATAWIDTH = 16,
    parameter int COEFWIDTH = 16
);
    logic                 fifo_empty;
    logic                 fifo_dequeue;
    logic [ADDRWIDTH-1:0] window_addr;
    logic [DATAWIDTH-1:0] sample_rdata;
    logic [COEFWIDTH-1:0] coef_rdata;
    logic [DATAWIDTH-1:0] m_data;
    logic                 m_valid;
    logic                 m_ready;
    logic                 m_first;
    logic                 m_last;

    modport master (
        input  fifo_empty, window_addr, sample_rdata, coef_rdata, m_ready,
        output fifo_dequeue, m_data, m_valid, m_first, m_last
    );

    modport slave (
        output fifo_empty, window_addr, sample_rdata, coef_rdata, m_ready,
        input  fifo_dequeue, m_data, m_valid, m_first, m_last
    );
endinterface

// File: rtl/window_apply.sv
// Windowing stage: dequeues samples, multiplies each by its window coefficient with
// round-half-up, and streams results to the FFT through a credit-protected 8-entry buffer.
module window_apply_chk (
    input logic       clock,
    input logic       reset_n,
    input logic       i_wr,
    input logic [3:0] i_count,
    input logic [3:0] i_credit
);
    a_no_overflow: assert property (@(posedge clock) disable iff (!reset_n)
        !(i_wr && (i_count == 4'd8)));
    a_credit_range: assert property (@(posedge clock) disable iff (!reset_n)
        (i_credit <= 4'd8));
endmodule

module window_apply #(
    parameter int ADDRWIDTH = 12,
    parameter int DATAWIDTH = 16,
    parameter int COEFWIDTH = 16
) (
    input logic           clock,
    input logic           reset_n,
    input logic           enable,
    window_apply_if.master bus
);
    localparam int PW = DATAWIDTH + COEFWIDTH + 1;
    localparam int EW = DATAWIDTH + 2;
    localparam logic [PW-1:0] ROUND_K = {{(PW-COEFWIDTH){1'b0}}, 1'b1, {(COEFWIDTH-1){1'b0}}};
    localparam logic [ADDRWIDTH-1:0] LAST_IDX = {ADDRWIDTH{1'b1}};

    logic [3:0]            r_credit;
    logic                  r_v0;
    logic [ADDRWIDTH-1:0]  r_tag0;
    logic                  r_v2;
    logic [ADDRWIDTH-1:0]  r_tag2;
    logic signed [PW-1:0]  r_prod2;
    logic [EW-1:0]         r_buf [0:7];
    logic [2:0]            r_wptr;
    logic [2:0]            r_rptr;
    logic [3:0]            r_count;

    logic                  w_pop;
    logic                  w_deq;
    logic                  w_mvalid;
    logic [PW-1:0]         w_samp_ext;
    logic [PW-1:0]         w_coef_ext;
    logic signed [PW-1:0]  w_prod;
    logic [PW-1:0]         w_sum;
    logic [DATAWIDTH-1:0]  w_result;
    logic [EW-1:0]         w_entry;
    logic [EW-1:0]         w_head;
    logic                  w_unused_sum;

    assign w_mvalid = (r_count != 4'd0);
    assign w_pop    = w_mvalid && bus.m_ready;
    assign w_deq    = reset_n && enable && !bus.fifo_empty && ((r_credit < 4'd8) || w_pop);

    // The RAM/ROM output registers act as stage 1: their data lines up with tag0/v0.
    assign w_samp_ext = {{(PW-DATAWIDTH){bus.sample_rdata[DATAWIDTH-1]}}, bus.sample_rdata};
    assign w_coef_ext = {{(PW-COEFWIDTH){1'b0}}, bus.coef_rdata};
    assign w_prod     = $signed(w_samp_ext) * $signed(w_coef_ext);

    // Arithmetic shift then truncation keeps exactly bits COEFWIDTH.. of the rounded sum.
    assign w_sum        = r_prod2 + ROUND_K;
    assign w_result     = w_sum[COEFWIDTH +: DATAWIDTH];
    assign w_unused_sum = ^{w_sum[PW-1 -: (PW-COEFWIDTH-DATAWIDTH)], w_sum[COEFWIDTH-1:0]};
    assign w_entry      = {w_result, (r_tag2 == {ADDRWIDTH{1'b0}}), (r_tag2 == LAST_IDX)};

    assign w_head           = r_buf[r_rptr];
    assign bus.fifo_dequeue = w_deq;
    assign bus.m_valid      = w_mvalid;
    assign bus.m_data       = w_head[EW-1:2];
    assign bus.m_first      = w_head[1];
    assign bus.m_last       = w_head[0];

    // Credit: samples issued and not yet popped from the output buffer.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_credit <= 4'd0;
        end else begin
            case ({w_deq, w_pop})
                2'b10:   r_credit <= r_credit + 4'd1;
                2'b01:   r_credit <= r_credit - 4'd1;
                default: r_credit <= r_credit;
            endcase
        end
    end

    // Issue and multiply stages carrying the in-window tag alongside each sample.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_v0    <= 1'b0;
            r_tag0  <= {ADDRWIDTH{1'b0}};
            r_v2    <= 1'b0;
            r_tag2  <= {ADDRWIDTH{1'b0}};
            r_prod2 <= {PW{1'b0}};
        end else begin
            r_v0 <= w_deq;
            if (w_deq) begin
                r_tag0 <= bus.window_addr;
            end
            r_v2 <= r_v0;
            if (r_v0) begin
                r_prod2 <= w_prod;
                r_tag2  <= r_tag0;
            end
        end
    end

    // Output buffer: rounded result written from the product stage, head popped by the FFT.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 8; i++) begin
                r_buf[i] <= {EW{1'b0}};
            end
            r_wptr  <= 3'd0;
            r_rptr  <= 3'd0;
            r_count <= 4'd0;
        end else begin
            if (r_v2) begin
                r_buf[r_wptr] <= w_entry;
                r_wptr        <= r_wptr + 3'd1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 3'd1;
            end
            case ({r_v2, w_pop})
                2'b10:   r_count <= r_count + 4'd1;
                2'b01:   r_count <= r_count - 4'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    window_apply_chk u_chk (
        .clock    (clock),
        .reset_n  (reset_n),
        .i_wr     (r_v2),
        .i_count  (r_count),
        .i_credit (r_credit)
    );
endmodule

// File: tb/tb_window_apply.sv
// Randomized and directed bench for window_apply against a queue-based behavioural model.
module tb_window_apply;
    localparam int AW = 4;
    localparam int DW = 16;
    localparam int CW = 16;

    typedef struct {
        logic [DW-1:0] d;
        logic          f;
        logic          l;
        int            t;
    } exp_t;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    logic enable = 1'b0;
    logic align_req = 1'b1;
    logic [DW-1:0] cur_sample = 16'h0000;
    logic [CW-1:0] cur_coef = 16'h0000;

    exp_t q[$];
    exp_t e_new;
    int checks = 0;
    int errors = 0;
    int cyc = 0;

    window_apply_if #(.ADDRWIDTH(AW), .DATAWIDTH(DW), .COEFWIDTH(CW)) bus ();

    window_apply #(.ADDRWIDTH(AW), .DATAWIDTH(DW), .COEFWIDTH(CW)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .enable  (enable),
        .bus     (bus.master)
    );

    always #5 clock = ~clock;

    // Windowing with round-half-up: floor((s*c + 2^15) / 2^16), s signed, c unsigned.
    function automatic logic [DW-1:0] win_mul(input logic [DW-1:0] s, input logic [CW-1:0] c);
        longint p;
        p = longint'($signed(s)) * longint'({1'b0, c});
        p = (p + 64'sd32768) >>> 16;
        return p[DW-1:0];
    endfunction

    function automatic bit model_valid();
        return (q.size() > 0) && (cyc >= q[0].t + 3);
    endfunction

    function automatic bit model_deq();
        bit pop;
        pop = model_valid() && bus.m_ready;
        return reset_n && enable && !bus.fifo_empty && ((q.size() < 8) || pop);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model update plus FIFO-manager / RAM / ROM stubs.
    always @(posedge clock) begin
        bit d;
        d = model_deq();
        if (!reset_n) begin
            q.delete();
        end else begin
            if (model_valid() && bus.m_ready) q.pop_front();
            if (d) begin
                e_new.d = win_mul(cur_sample, cur_coef);
                e_new.f = (bus.window_addr == 4'd0);
                e_new.l = (bus.window_addr == 4'd15);
                e_new.t = cyc;
                q.push_back(e_new);
            end
        end
        if (bus.fifo_dequeue) begin
            bus.sample_rdata <= cur_sample;
            bus.coef_rdata   <= cur_coef;
        end else begin
            bus.sample_rdata <= 16'($urandom);
            bus.coef_rdata   <= 16'($urandom);
        end
        if (align_req) bus.window_addr <= 4'd0;
        else if (bus.fifo_dequeue) bus.window_addr <= bus.window_addr + 4'd1;
        cyc = cyc + 1;
    end

    // Compare DUT outputs against the model every cycle.
    always @(negedge clock) begin
        if (!reset_n) begin
            chk("rst_m_valid", bus.m_valid, 0);
            chk("rst_m_first", bus.m_first, 0);
            chk("rst_m_last", bus.m_last, 0);
            chk("rst_m_data", bus.m_data, 0);
            chk("rst_dequeue", bus.fifo_dequeue, 0);
        end else begin
            chk("m_valid", bus.m_valid, model_valid());
            if (model_valid()) begin
                chk("m_data", bus.m_data, q[0].d);
                chk("m_first", bus.m_first, q[0].f);
                chk("m_last", bus.m_last, q[0].l);
            end
            chk("fifo_dequeue", bus.fifo_dequeue, model_deq());
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    // One isolated sample: dequeue now, m_valid only three cycles later.
    task automatic issue_one(input logic [15:0] s, input logic [15:0] c,
                             input logic [15:0] exp_d, input logic exp_f);
        cur_sample = s;
        cur_coef = c;
        bus.fifo_empty = 1'b0;
        #1;
        chk("one_dequeue", bus.fifo_dequeue, 1);
        tick(1);
        bus.fifo_empty = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            #3;
            chk("one_latency", bus.m_valid, (k == 3));
            if (k == 3) begin
                chk("one_data", bus.m_data, exp_d);
                chk("one_first", bus.m_first, exp_f);
            end
            tick(1);
        end
    endtask

    initial begin
        int n_deq;
        int n_val;
        int n_first;
        int n_last;
        bus.fifo_empty = 1'b1;
        bus.m_ready = 1'b1;

        chk("pin_a", win_mul(16'hFFFF, 16'h8000), 16'h0000);
        chk("pin_b", win_mul(16'h7FFF, 16'hFFFF), 16'h7FFF);
        chk("pin_c", win_mul(16'h8000, 16'hFFFF), 16'h8001);
        chk("pin_d", win_mul(16'h0001, 16'h8000), 16'h0001);
        chk("pin_e", win_mul(16'h4000, 16'h8000), 16'h2000);

        tick(3);
        reset_n = 1'b1;
        align_req = 1'b0;
        enable = 1'b1;

        issue_one(16'h4000, 16'h8000, 16'h2000, 1'b1);
        issue_one(16'hFFFF, 16'h8000, 16'h0000, 1'b0);
        issue_one(16'h7FFF, 16'hFFFF, 16'h7FFF, 1'b0);
        issue_one(16'h8000, 16'hFFFF, 16'h8001, 1'b0);
        issue_one(16'h0001, 16'h8000, 16'h0001, 1'b0);

        // Full frame from index 0.
        align_req = 1'b1;
        tick(1);
        align_req = 1'b0;
        n_deq = 0; n_val = 0; n_first = 0; n_last = 0;
        for (int i = 0; i < 24; i++) begin
            bus.fifo_empty = (i >= 16);
            cur_sample = 16'($urandom);
            cur_coef = 16'($urandom);
            #1;
            n_deq += int'(bus.fifo_dequeue);
            #2;
            n_val += int'(bus.m_valid);
            n_first += int'(bus.m_valid && bus.m_first);
            n_last += int'(bus.m_valid && bus.m_last);
            if (i == 18) chk("frame_last_pos", bus.m_valid && bus.m_last, 1);
            if (i == 3) chk("frame_first_pos", bus.m_valid && bus.m_first, 1);
            tick(1);
        end
        chk("frame_dequeues", n_deq, 16);
        chk("frame_valids", n_val, 16);
        chk("frame_firsts", n_first, 1);
        chk("frame_lasts", n_last, 1);

        // Backpressure: only 8 samples may be issued while the FFT stalls.
        bus.m_ready = 1'b0;
        bus.fifo_empty = 1'b0;
        n_deq = 0;
        for (int i = 0; i < 20; i++) begin
            cur_sample = 16'($urandom);
            cur_coef = 16'($urandom);
            #1;
            n_deq += int'(bus.fifo_dequeue);
            tick(1);
        end
        chk("bp_dequeues", n_deq, 8);
        chk("bp_stalled", bus.fifo_dequeue, 0);
        bus.m_ready = 1'b1;
        #1;
        chk("bp_resume", bus.fifo_dequeue, 1);
        tick(4);
        bus.fifo_empty = 1'b1;
        tick(14);

        // Reset with 5 samples buffered.
        bus.m_ready = 1'b0;
        bus.fifo_empty = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cur_sample = 16'($urandom);
            cur_coef = 16'($urandom);
            tick(1);
        end
        bus.fifo_empty = 1'b1;
        tick(5);
        chk("pre_rst_valid", bus.m_valid, 1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_rst_valid", bus.m_valid, 0);
        tick(2);
        reset_n = 1'b1;
        bus.m_ready = 1'b1;
        issue_one(16'h1234, 16'hC000, 16'h0DA7, 1'b0);

        // Randomized traffic.
        for (int i = 0; i < 800; i++) begin
            enable = ($urandom_range(9) != 0);
            bus.fifo_empty = ($urandom_range(2) == 0);
            bus.m_ready = ($urandom_range(3) != 0);
            cur_sample = 16'($urandom);
            cur_coef = 16'($urandom);
            tick(1);
        end
        enable = 1'b0;
        bus.m_ready = 1'b1;
        tick(20);
        chk("drained", bus.m_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
